dmem_responder: RTL and testbench

Responder side of the pipeline's data-memory port: accepts load/store requests from the CPU's MEM stage over a valid/ready handshake, services them against an internal word-addressed array after a configurable number of wait states, and returns read data or a write completion on a separate valid/ready response channel. It replaces the zero-latency data memory when the pipeline is built with stall-on-memory support, and is the block the MEM-stage request logic talks to.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 33 +++
 rtl/dmem_responder_array.sv | 38 +++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared constants for the data-memory responder: data/byte-enable widths,
// wait-state counter sizing and the FSM state encoding.
package dmem_responder_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int BE_WIDTH    = WORD_WIDTH / 8;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_WIDTH   = 4;
    localparam int STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bus between the MEM-stage requester (master) and the
// data-memory responder (slave).
//   req_*  : request channel, master -> slave (req_ready back)
//   resp_* : response channel, slave -> master (resp_ready back)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source holds valid and payload stable until that edge;
// ready may be raised or lowered freely and never waits for valid.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic [BE_WIDTH-1:0]   req_be;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WORD_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array
// Word-addressed storage for the responder: synchronous byte-enabled write,
// combinational read.
//   clk   : write clock
//   we    : write enable (gated by be per byte)
//   addr  : word address shared by read and write
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   wdata : write data
//   rdata : combinational read of mem[addr]
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH    = 10,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder with a fixed number of wait states. Accepts one
// load/store at a time, commits it to the array on the edge that enters
// RESP, then holds the response until the requester takes it.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/response channels (slave side)
//   busy     : a request is in flight
//   dbgState : current FSM state (ST_IDLE/ST_WAIT/ST_RESP)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH    = 10,
    parameter int    LATENCY       = 2,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    dmem_responder_if.slave        bus,
    output logic                   busy,
    output logic [STATE_WIDTH-1:0] dbgState
);

    localparam logic [CNT_WIDTH-1:0] LAT_CNT  = CNT_WIDTH'(LATENCY);
    localparam bit                   ZERO_LAT = (LATENCY == 0);

    logic [STATE_WIDTH-1:0] stateQ;
    logic [CNT_WIDTH-1:0]   cntQ;
    logic                   wrQ;
    logic [31:0]            addrQ;
    logic [WORD_WIDTH-1:0]  wdataQ;
    logic [BE_WIDTH-1:0]    beQ;
    logic [WORD_WIDTH-1:0]  rdataQ;
    logic                   errQ;

    // With zero wait states the commit happens on the accepting edge, so the
    // commit path must see the live request rather than the latches.
    logic                   cWrite;
    logic [31:0]            cAddr;
    logic [WORD_WIDTH-1:0]  cWdata;
    logic [BE_WIDTH-1:0]    cBe;
    logic                   cErr;
    logic                   commit;
    logic                   arrWe;
    logic [WORD_WIDTH-1:0]  arrRdata;
    logic [WORD_WIDTH-1:0]  rdataNext;

    assign cWrite = (stateQ == ST_IDLE) ? bus.req_write : wrQ;
    assign cAddr  = (stateQ == ST_IDLE) ? bus.req_addr  : addrQ;
    assign cWdata = (stateQ == ST_IDLE) ? bus.req_wdata : wdataQ;
    assign cBe    = (stateQ == ST_IDLE) ? bus.req_be    : beQ;

    // Misaligned, or any address bit above the array's byte range set.
    assign cErr = (cAddr[1:0] != 2'b00) || ((cAddr >> (ADDR_WIDTH + 2)) != 32'd0);

    assign commit = ((stateQ == ST_IDLE) && bus.req_valid && ZERO_LAT) ||
                    ((stateQ == ST_WAIT) && (cntQ == 4'd1));

    assign arrWe     = commit && cWrite && !cErr;
    assign rdataNext = (cWrite || cErr) ? '0 : arrRdata;

    dmem_array #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) uArray (
        .clk   (clk),
        .we    (arrWe),
        .addr  (cAddr[ADDR_WIDTH+1:2]),
        .be    (cBe),
        .wdata (cWdata),
        .rdata (arrRdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= ST_IDLE;
            cntQ   <= '0;
            wrQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            beQ    <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wrQ    <= bus.req_write;
                        addrQ  <= bus.req_addr;
                        wdataQ <= bus.req_wdata;
                        beQ    <= bus.req_be;
                        cntQ   <= LAT_CNT;
                        stateQ <= ZERO_LAT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cntQ <= cntQ - 1'b1;
                    if (cntQ == 4'd1) stateQ <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        stateQ <= ST_IDLE;
                        rdataQ <= '0;
                        errQ   <= 1'b0;
                    end
                end
                default: stateQ <= ST_IDLE;
            endcase
            // Response payload is captured once, on the edge entering RESP.
            if (commit) begin
                rdataQ <= rdataNext;
                errQ   <= cErr;
            end
        end
    end

    assign bus.req_ready  = (stateQ == ST_IDLE);
    assign bus.resp_valid = (stateQ == ST_RESP);
    assign bus.resp_rdata = rdataQ;
    assign bus.resp_err   = errQ;
    assign busy           = (stateQ != ST_IDLE);
    assign dbgState       = stateQ;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Three responders (LATENCY 2, 0, 1) driven from shared stimulus arrays.
// A transaction-level model predicts every output on every falling edge.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int AW   = 10;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // stimulus
    logic [NDUT-1:0] reqValid  = '0;
    logic [NDUT-1:0] reqWrite  = '0;
    logic [NDUT-1:0] respReady = '0;
    logic [31:0]     reqAddr  [NDUT];
    logic [31:0]     reqWdata [NDUT];
    logic [3:0]      reqBe    [NDUT];

    // observed
    logic [NDUT-1:0] reqReadyObs;
    logic [NDUT-1:0] respValidObs;
    logic [NDUT-1:0] errObs;
    logic [NDUT-1:0] busyObs;
    logic [31:0]     rdataObs [NDUT];
    logic [1:0]      stateObs [NDUT];

    int vecCnt  = 0;
    int missCnt = 0;

    function automatic int latOf(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        dmem_responder_if bus ();
        assign bus.req_valid  = reqValid[g];
        assign bus.req_write  = reqWrite[g];
        assign bus.req_addr   = reqAddr[g];
        assign bus.req_wdata  = reqWdata[g];
        assign bus.req_be     = reqBe[g];
        assign bus.resp_ready = respReady[g];
        assign reqReadyObs[g]  = bus.req_ready;
        assign respValidObs[g] = bus.resp_valid;
        assign errObs[g]       = bus.resp_err;
        assign rdataObs[g]     = bus.resp_rdata;

        dmem_responder #(
            .ADDR_WIDTH    (AW),
            .LATENCY       ((g == 0) ? 2 : ((g == 1) ? 0 : 1)),
            .MEM_INIT_FILE ("")
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .busy     (busyObs[g]),
            .dbgState (stateObs[g])
        );
    end

    // ---------------- behavioural model ----------------
    int          edgeCnt = 0;
    bit          mPend     [NDUT];
    int          mRespEdge [NDUT];
    bit          mWr       [NDUT];
    logic [31:0] mAddr     [NDUT];
    logic [31:0] mWdata    [NDUT];
    logic [3:0]  mBe       [NDUT];
    logic [31:0] mExpData  [NDUT];
    bit          mExpErr   [NDUT];
    bit          mExpKnown [NDUT];
    logic [31:0] modelMem  [int];
    int          accLog    [$];

    task automatic modelCommit(input int d);
        bit          err;
        int          key;
        logic [31:0] word;
        err  = (mAddr[d] % 4 != 0) || (mAddr[d] >= (32'd1 << (AW + 2)));
        key  = d * 1024 + int'((mAddr[d] / 4) % 1024);
        mExpErr[d]   = err;
        mExpKnown[d] = 1'b1;
        mExpData[d]  = '0;
        if (!err && mWr[d]) begin
            word = modelMem.exists(key) ? modelMem[key] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (mBe[d][b]) word[8*b +: 8] = mWdata[d][8*b +: 8];
            modelMem[key] = word;
        end else if (!err) begin
            if (modelMem.exists(key)) mExpData[d] = modelMem[key];
            else mExpKnown[d] = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NDUT; d++) mPend[d] = 1'b0;
        end else begin
            edgeCnt = edgeCnt + 1;
            for (int d = 0; d < NDUT; d++) begin
                if (!mPend[d]) begin
                    if (reqValid[d]) begin
                        mPend[d]     = 1'b1;
                        mRespEdge[d] = edgeCnt + latOf(d);
                        mWr[d]       = reqWrite[d];
                        mAddr[d]     = reqAddr[d];
                        mWdata[d]    = reqWdata[d];
                        mBe[d]       = reqBe[d];
                        if (d == 2) accLog.push_back(edgeCnt);
                    end
                end else if (mRespEdge[d] < edgeCnt && respReady[d]) begin
                    mPend[d] = 1'b0;
                end
                if (mPend[d] && mRespEdge[d] == edgeCnt) modelCommit(d);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic       eResp, eRdy, eBusy, eErr, chkData, bad;
        logic [31:0] eData;
        logic [1:0]  eState;
        for (int d = 0; d < NDUT; d++) begin
            eResp   = mPend[d] && (mRespEdge[d] <= edgeCnt);
            eRdy    = !mPend[d];
            eBusy   = mPend[d];
            eErr    = eResp && mExpErr[d];
            eData   = eResp ? mExpData[d] : 32'd0;
            chkData = !eResp || mExpKnown[d];
            eState  = !mPend[d] ? ST_IDLE : (eResp ? ST_RESP : ST_WAIT);
            bad = (reqReadyObs[d] !== eRdy) || (respValidObs[d] !== eResp) ||
                  (busyObs[d] !== eBusy) || (errObs[d] !== eErr) ||
                  (stateObs[d] !== eState) || (chkData && (rdataObs[d] !== eData));
            vecCnt++;
            if (bad) begin
                missCnt++;
                $display("FAIL outputs[%0d] t=%0t rdy/val/busy/err/st got %b%b%b%b/%0d want %b%b%b%b/%0d rdata got %h want %h",
                         d, $time, reqReadyObs[d], respValidObs[d], busyObs[d], errObs[d], stateObs[d],
                         eRdy, eResp, eBusy, eErr, eState, rdataObs[d], eData);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    // Called and returns at posedge+2.
    task automatic doReq(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int stall,
                         output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        rdata = '0; err = 1'b0; lat = 0; guard = 0;
        reqValid[d] = 1'b1; reqWrite[d] = wr; reqAddr[d] = addr;
        reqWdata[d] = wdata; reqBe[d] = be; respReady[d] = (stall == 0);
        do begin @(negedge clk); guard++; end while (!reqReadyObs[d] && guard < 50);
        check("accept", 32'(reqReadyObs[d]), 32'd1);
        if (!reqReadyObs[d]) begin reqValid[d] = 1'b0; return; end
        @(posedge clk); #2;
        // Keep a random request asserted while busy; it must not be taken.
        reqWrite[d] = 1'($urandom_range(0, 1));
        reqAddr[d]  = 32'($urandom_range(0, 63));
        reqWdata[d] = $urandom;
        reqBe[d]    = 4'($urandom_range(0, 15));
        do begin @(negedge clk); lat++; end while (!respValidObs[d] && lat < 40);
        check("resp_seen", 32'(respValidObs[d]), 32'd1);
        rdata = rdataObs[d]; err = errObs[d];
        @(posedge clk); #2;
        reqValid[d] = 1'b0;
        if (stall > 0) begin
            repeat (stall - 1) @(posedge clk);
            #2 respReady[d] = 1'b1;
            @(posedge clk); #2;
        end
        respReady[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] rd;
    logic        er;
    int          lt;
    logic [31:0] expQ [$];

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            reqAddr[d] = '0; reqWdata[d] = '0; reqBe[d] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_ready", 32'(reqReadyObs[d]), 32'd1);
            check("rst_valid", 32'(respValidObs[d]), 32'd0);
        end
        @(posedge clk); #2;

        // known contents for words 0..15 of every instance; 0x30 starts at 0
        for (int d = 0; d < NDUT; d++)
            for (int w = 0; w < 16; w++)
                doReq(d, 1'b1, 32'(w * 4), (w == 12) ? 32'd0 : $urandom, 4'hF, 0, rd, er, lt);

        // full store then load, LATENCY=2
        doReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lt);
        check("st_lat", 32'(lt), 32'd3);
        check("st_rdata", rd, 32'd0);
        check("st_err", 32'(er), 32'd0);
        doReq(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lt);
        check("ld_lat", 32'(lt), 32'd3);
        check("ld_rdata", rd, 32'hDEADBEEF);

        // partial store
        doReq(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lt);
        doReq(0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010, 1, rd, er, lt);
        doReq(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lt);
        check("partial", rd, 32'h1122AB44);

        // error cases leave neighbours alone
        doReq(0, 1'b1, 32'h04, 32'h5A5A5A5A, 4'hF, 0, rd, er, lt);
        doReq(0, 1'b0, 32'h02, 32'h0, 4'hF, 0, rd, er, lt);
        check("misal_err", 32'(er), 32'd1);
        check("misal_rdata", rd, 32'd0);
        doReq(0, 1'b0, 32'h1 << (AW + 2), 32'h0, 4'hF, 0, rd, er, lt);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        doReq(0, 1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, 0, rd, er, lt);
        check("misal_st_err", 32'(er), 32'd1);
        doReq(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, rd, er, lt);
        check("adjacent", rd, 32'h5A5A5A5A);

        // LATENCY=0 with a 5-cycle stall
        doReq(1, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 0, rd, er, lt);
        doReq(1, 1'b0, 32'h08, 32'h0, 4'h0, 5, rd, er, lt);
        check("lat0_lat", 32'(lt), 32'd1);
        check("lat0_rdata", rd, 32'hCAFEF00D);

        // reset mid-WAIT abandons the store
        reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqAddr[0] = 32'h30;
        reqWdata[0] = 32'hFFFFFFFF; reqBe[0] = 4'hF; respReady[0] = 1'b0;
        @(negedge clk);
        check("rst_acc", 32'(reqReadyObs[0]), 32'd1);
        @(posedge clk); #2 reqValid[0] = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("midrst_ready", 32'(reqReadyObs[0]), 32'd1);
        check("midrst_valid", 32'(respValidObs[0]), 32'd0);
        check("midrst_busy", 32'(busyObs[0]), 32'd0);
        check("midrst_err", 32'(errObs[0]), 32'd0);
        check("midrst_rdata", rdataObs[0], 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        doReq(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lt);
        check("abandoned", rd, 32'd0);

        // back-to-back loads, LATENCY=1
        for (int i = 0; i < 6; i++)
            doReq(2, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF, 0, rd, er, lt);
        accLog.delete();
        for (int i = 0; i < 6; i++) expQ.push_back(32'hC0DE0000 + 32'(i));
        begin
            int k, got;
            bit accNow;
            k = 0; got = 0;
            reqWrite[2] = 1'b0; reqAddr[2] = 32'h0; reqBe[2] = 4'h0;
            reqValid[2] = 1'b1; respReady[2] = 1'b1;
            for (int c = 0; c < 60 && got < 6; c++) begin
                @(negedge clk);
                if (respValidObs[2]) begin
                    check("b2b_order", rdataObs[2], expQ.pop_front());
                    got++;
                end
                accNow = reqReadyObs[2] && reqValid[2];
                @(posedge clk); #2;
                if (accNow) begin
                    k++;
                    if (k == 6) reqValid[2] = 1'b0;
                    else reqAddr[2] = 32'(k * 4);
                end
            end
            reqValid[2] = 1'b0; respReady[2] = 1'b0;
            check("b2b_count", 32'(got), 32'd6);
        end
        check("b2b_acc", 32'(accLog.size()), 32'd6);
        for (int i = 1; i < accLog.size(); i++)
            check("b2b_gap", 32'(accLog[i] - accLog[i-1]), 32'd3);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            int          d, sel;
            logic [31:0] a;
            d   = $urandom_range(0, NDUT - 1);
            a   = 32'($urandom_range(0, 15) * 4);
            sel = $urandom_range(0, 7);
            if (sel == 0) a = a | 32'($urandom_range(1, 3));
            else if (sel == 1) a = a | (32'h1 << $urandom_range(AW + 2, 31));
            doReq(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), rd, er, lt);
            check("rand_lat", 32'(lt), 32'(1 + latOf(d)));
            idle($urandom_range(0, 2));
        end

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t simulation did not complete", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
